// File: rtl/low_power_approx_adder_pkg.sv
// low_power_approx_adder_pkg: shared widths and cell mode constants for the approximate adder
package low_power_approx_adder_pkg;
    localparam int   ADD_WIDTH   = 4;
    localparam int   MASK_WIDTH  = ADD_WIDTH - 1;
    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;
endpackage

// File: rtl/low_power_approx_adder_fa_cell.sv
// approx_fa_cell: one adder bit, exact full adder or carry-breaking OR/AND approximation
module approx_fa_cell
    import low_power_approx_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    input  logic mode,
    output logic s,
    output logic c_out
);
    logic w_a, w_b, w_c;
    // exact-path inputs are forced low in approximate mode so that logic stays quiet
    always_comb begin
        w_a   = a & mode;
        w_b   = b & mode;
        w_c   = c_in & mode;
        s     = (mode == MODE_EXACT) ? (w_a ^ w_b ^ w_c) : (a | b);
        c_out = (mode == MODE_EXACT) ? ((w_a & w_b) | (w_a & w_c) | (w_b & w_c)) : (a & b);
    end
endmodule

// File: rtl/low_power_approx_adder.sv
// low_power_approx_adder: mask-configurable approximate ripple adder with registered sum
module low_power_approx_adder
    import low_power_approx_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-2:0] mask,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry_unused;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    assign w_c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == WIDTH - 1) begin : g_msb
            approx_fa_cell u_cell (
                .a     (in1[i]),
                .b     (in2[i]),
                .c_in  (w_c[i]),
                .mode  (MODE_EXACT),
                .s     (w_sum[i]),
                .c_out (w_carry_unused)
            );
        end else begin : g_lo
            approx_fa_cell u_cell (
                .a     (in1[i]),
                .b     (in2[i]),
                .c_in  (w_c[i]),
                .mode  (mask[i]),
                .s     (w_sum[i]),
                .c_out (w_c[i+1])
            );
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) r_out <= w_sum;
        end
    end
    assign out       = r_out;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_low_power_approx_adder.sv
// tb_low_power_approx_adder: table, exhaustive, random and reset checks against a bit-rule model
module tb_low_power_approx_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in1 = '0, in2 = '0;
    logic [2:0] mask = '0;
    logic       in_valid = 1'b0;
    logic [3:0] out;
    logic       out_valid;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] m;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    low_power_approx_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in2       (in2),
        .mask      (mask),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    function automatic logic [3:0] model(input int a, input int b, input int m);
        int c = 0;
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            int ai = (a >> i) & 1;
            int bi = (b >> i) & 1;
            if (i == 3 || ((m >> i) & 1) == 1) begin
                int t = ai + bi + c;
                r = r + (t % 2) * (1 << i);
                c = t / 2;
            end else begin
                r = r + (ai | bi) * (1 << i);
                c = ai & bi;
            end
        end
        return 4'(r);
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] m, input logic v);
        @(negedge clk);
        in1 = a;
        in2 = b;
        mask = m;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e_out;
        logic       e_v;
        tbl[0] = '{4'b1010, 4'b1100, 3'b111, 4'b0110};
        tbl[1] = '{4'b1111, 4'b0001, 3'b111, 4'b0000};
        tbl[2] = '{4'b0011, 4'b0001, 3'b000, 4'b0011};
        tbl[3] = '{4'b0011, 4'b0001, 3'b001, 4'b0010};
        tbl[4] = '{4'b0011, 4'b0001, 3'b111, 4'b0100};
        tbl[5] = '{4'b1010, 4'b1100, 3'b000, 4'b0110};

        #2;
        chk("reset_out", out, 4'b0000);
        chk("reset_valid", {3'b0, out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].m, 1'b1);
            chk($sformatf("table%0d_out", i), out, tbl[i].exp);
            chk($sformatf("table%0d_valid", i), {3'b0, out_valid}, 4'b0001);
        end

        drive(4'b0101, 4'b0110, 3'b111, 1'b0);
        chk("hold_out", out, 4'b0110);
        chk("hold_valid", {3'b0, out_valid}, 4'b0000);
        drive(4'b0101, 4'b0110, 3'b111, 1'b0);
        chk("hold2_out", out, 4'b0110);

        drive(4'b1010, 4'b1100, 3'b111, 1'b1);
        chk("pre_reset_out", out, 4'b0110);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", out, 4'b0000);
        chk("async_reset_valid", {3'b0, out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0111, 4'b0001, 3'b111, 1'b1);
        chk("post_reset_out", out, 4'b1000);
        chk("post_reset_valid", {3'b0, out_valid}, 4'b0001);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int m = 0; m < 8; m++) begin
                    drive(4'(a), 4'(b), 3'(m), 1'b1);
                    chk($sformatf("exh a=%0d b=%0d m=%0d", a, b, m), out, model(a, b, m));
                end

        e_out = out;
        for (int k = 0; k < 400; k++) begin
            logic [3:0] ra, rb;
            logic [2:0] rm;
            logic       rv;
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            rm = 3'($urandom_range(7));
            rv = 1'($urandom_range(1));
            if (rv) e_out = model(int'(ra), int'(rb), int'(rm));
            e_v = rv;
            drive(ra, rb, rm, rv);
            chk($sformatf("rand%0d_out", k), out, e_out);
            chk($sformatf("rand%0d_valid", k), {3'b0, out_valid}, {3'b0, e_v});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
